mutex_system_n: RTL and testbench



---
 rtl/mutex_system_n.sv | 145 ++++++++++++++
 tb/tb_mutex_system_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mutex_system_n.sv
// N-client mutual-exclusion rule engine: one encoded (client, rule) per cycle, optional oldest-waiter fairness.
// Latency: a rule presented before an edge is visible on every output after that edge; err lags state by one cycle.
// Backpressure: none; a rule whose guard is false (or an out-of-range index) is dropped and reported via io_fired=0.
module mutex_system_n #(
  parameter int N_CLIENTS = 3,
  parameter int STARVE_W  = 8,
  parameter int FAIR      = 0,
  localparam int RULE_W   = $clog2(4 * N_CLIENTS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [RULE_W-1:0]      io_en_a,
  output logic [2*N_CLIENTS-1:0] io_state,
  output logic                   io_x,
  output logic                   io_fired,
  output logic [N_CLIENTS-1:0]   io_starve,
  output logic [15:0]            io_crit_count,
  output logic                   io_mutex_err
);

  localparam int CW = RULE_W - 2;
  localparam logic [RULE_W:0] RULE_LIM = (RULE_W + 1)'(4 * N_CLIENTS);

  typedef enum logic [1:0] {ST_I = 2'd0, ST_T = 2'd1, ST_C = 2'd2, ST_E = 2'd3} cstate_t;

  logic [2*N_CLIENTS-1:0]              state_q, state_d;
  logic [N_CLIENTS-1:0][STARVE_W-1:0]  wait_q, wait_d;
  logic                                x_q, x_d;
  logic [15:0]                         crit_q, crit_d;
  logic                                fired_q;
  logic                                err_q;

  logic [CW-1:0]       cli;
  logic [1:0]          kind;
  logic                hit;
  logic [1:0]          cur;
  logic [1:0]          nxt;
  logic [STARVE_W-1:0] cur_wait;
  logic                fair_ok;
  logic                fire;
  logic [4:0]          n_crit;
  logic                viol;

  always_comb begin
    cli      = io_en_a[RULE_W-1:2];
    kind     = io_en_a[1:0];
    hit      = ({1'b0, io_en_a} < RULE_LIM);
    cur      = ST_I;
    cur_wait = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (cli == CW'(i)) begin
        cur      = state_q[2*i +: 2];
        cur_wait = wait_q[i];
      end
    end

    // Oldest waiter wins; equal ages are broken towards the lower client index.
    fair_ok = 1'b1;
    for (int j = 0; j < N_CLIENTS; j++) begin
      if (FAIR != 0 && cli != CW'(j) && state_q[2*j +: 2] == ST_T) begin
        if (!(cur_wait > wait_q[j] || (cur_wait == wait_q[j] && cli < CW'(j))))
          fair_ok = 1'b0;
      end
    end

    fire   = 1'b0;
    nxt    = cur;
    x_d    = x_q;
    crit_d = crit_q;
    if (hit) begin
      case (kind)
        2'd0: if (cur == ST_I) begin
          fire = 1'b1;
          nxt  = ST_T;
        end
        2'd1: if (cur == ST_T && x_q && fair_ok) begin
          fire   = 1'b1;
          nxt    = ST_C;
          x_d    = 1'b0;
          crit_d = crit_q + 16'd1;
        end
        2'd2: if (cur == ST_C) begin
          fire = 1'b1;
          nxt  = ST_E;
        end
        default: if (cur == ST_E) begin
          fire = 1'b1;
          nxt  = ST_I;
          x_d  = 1'b1;
        end
      endcase
    end

    state_d = state_q;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (fire && cli == CW'(i))
        state_d[2*i +: 2] = nxt;
    end

    // Counters only run while a client stays in T; leaving T on this edge wins over the increment.
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (state_q[2*i +: 2] == ST_T && state_d[2*i +: 2] == ST_T)
        wait_d[i] = (&wait_q[i]) ? wait_q[i] : wait_q[i] + 1'b1;
      else
        wait_d[i] = '0;
    end

    n_crit = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (state_q[2*i +: 2] == ST_C)
        n_crit = n_crit + 5'd1;
    end
    viol = (n_crit > 5'd1) || (n_crit != 5'd0 && x_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      wait_q  <= '0;
      x_q     <= 1'b1;
      crit_q  <= '0;
      fired_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      x_q     <= x_d;
      crit_q  <= crit_d;
      fired_q <= fire;
      err_q   <= err_q | viol;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++)
      io_starve[i] = &wait_q[i];
  end

  assign io_state      = state_q;
  assign io_x          = x_q;
  assign io_fired      = fired_q;
  assign io_crit_count = crit_q;
  assign io_mutex_err  = err_q;

endmodule

// File: tb/tb_mutex_system_n.sv
// Bench for mutex_system_n: a FAIR=0 and a FAIR=1 instance share one rule stream and are
// checked every cycle against a queue/arithmetic model, with directed scenarios pinning literal values.
module tb_mutex_system_n;
  localparam int NC = 3;

  logic        clock;
  logic        reset;
  logic [3:0]  en;

  logic [5:0]  s0, s1;
  logic        x0, x1, f0, f1, e0, e1;
  logic [2:0]  st0, st1;
  logic [15:0] cc0, cc1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit chk_en = 0;

  mutex_system_n #(.N_CLIENTS(NC), .STARVE_W(8), .FAIR(0)) dut0 (
    .clock(clock), .reset(reset), .io_en_a(en), .io_state(s0), .io_x(x0),
    .io_fired(f0), .io_starve(st0), .io_crit_count(cc0), .io_mutex_err(e0));

  mutex_system_n #(.N_CLIENTS(NC), .STARVE_W(8), .FAIR(1)) dut1 (
    .clock(clock), .reset(reset), .io_en_a(en), .io_state(s1), .io_x(x1),
    .io_fired(f1), .io_starve(st1), .io_crit_count(cc1), .io_mutex_err(e1));

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state per client, entry time into T, age derived from elapsed edges.
  int     ms   [2][NC];
  longint ment [2][NC];
  bit     mx   [2];
  int     mcrit[2];
  bit     mfired[2];
  bit     merr [2];
  longint cyc = 0;
  int     mc, mk, nc_cnt;
  bit     mf;

  function automatic longint mwait(int m, int i);
    longint w;
    if (ms[m][i] != 1) return 0;
    w = cyc - ment[m][i];
    return (w > 255) ? 255 : w;
  endfunction

  function automatic bit is_oldest(int m, int c);
    for (int j = 0; j < NC; j++) begin
      if (j != c && ms[m][j] == 1) begin
        if (!(mwait(m, c) > mwait(m, j) || (mwait(m, c) == mwait(m, j) && c < j)))
          return 0;
      end
    end
    return 1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < NC; i++) begin
          ms[m][i]   = 0;
          ment[m][i] = 0;
        end
        mx[m] = 1; mcrit[m] = 0; mfired[m] = 0; merr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        nc_cnt = 0;
        for (int i = 0; i < NC; i++) if (ms[m][i] == 2) nc_cnt++;
        if (nc_cnt > 1 || (nc_cnt > 0 && mx[m])) merr[m] = 1;
        mc = int'(en) / 4;
        mk = int'(en) % 4;
        mf = 0;
        if (mc < NC) begin
          case (mk)
            0: if (ms[m][mc] == 0) begin mf = 1; ms[m][mc] = 1; ment[m][mc] = cyc + 1; end
            1: if (ms[m][mc] == 1 && mx[m] && (m == 0 || is_oldest(m, mc))) begin
                 mf = 1; ms[m][mc] = 2; mx[m] = 0; mcrit[m] = (mcrit[m] + 1) % 65536;
               end
            2: if (ms[m][mc] == 2) begin mf = 1; ms[m][mc] = 3; end
            default: if (ms[m][mc] == 3) begin mf = 1; ms[m][mc] = 0; mx[m] = 1; end
          endcase
        end
        mfired[m] = mf;
      end
      cyc++;
    end
  end

  task automatic cmp_inst(input int m, input logic [5:0] s, input logic x, input logic f,
                          input logic [2:0] st, input logic [15:0] cc, input logic e);
    longint es, est;
    es = 0; est = 0;
    for (int i = 0; i < NC; i++) begin
      es  = es + (longint'(ms[m][i]) << (2 * i));
      if (mwait(m, i) == 255) est = est + (longint'(1) << i);
    end
    check($sformatf("m%0d.state", m),  s,  es);
    check($sformatf("m%0d.x", m),      x,  mx[m]);
    check($sformatf("m%0d.fired", m),  f,  mfired[m]);
    check($sformatf("m%0d.starve", m), st, est);
    check($sformatf("m%0d.crit", m),   cc, mcrit[m]);
    check($sformatf("m%0d.err", m),    e,  merr[m]);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp_inst(0, s0, x0, f0, st0, cc0, e0);
      cmp_inst(1, s1, x1, f1, st1, cc1, e1);
    end
  end

  task automatic step(input logic [3:0] r);
    en = r;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    en = 4'd15;
    #2 reset = 0;
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    reset = 0;
    en    = 4'd15;
    repeat (2) @(negedge clock);
    reset  = 1;
    chk_en = 1;

    // Idle with an out-of-range rule
    for (int i = 0; i < 4; i++) begin
      step(4'd15);
      check("idle.state", s0, 0); check("idle.x", x0, 1);
      check("idle.fired", f0, 0); check("idle.crit", cc0, 0);
    end

    // Client 0 full cycle
    step(4'd0); check("c0.try.state", s0, 6'h01); check("c0.try.x", x0, 1); check("c0.try.fired", f0, 1);
    step(4'd1); check("c0.crit.state", s0, 6'h02); check("c0.crit.x", x0, 0); check("c0.crit.fired", f0, 1);
    step(4'd2); check("c0.exit.state", s0, 6'h03); check("c0.exit.x", x0, 0); check("c0.exit.fired", f0, 1);
    step(4'd3); check("c0.idle.state", s0, 6'h00); check("c0.idle.x", x0, 1); check("c0.idle.fired", f0, 1);
    check("c0.crit_count", cc0, 1);

    // Contention without fairness
    do_reset;
    step(4'd0); step(4'd4);
    step(4'd5); check("cont.c1crit.fired", f0, 1); check("cont.c1crit.x", x0, 0); check("cont.c1crit.state", s0, 6'h09);
    step(4'd1); check("cont.c0reject.fired", f0, 0); check("cont.c0reject.state", s0, 6'h09);
    step(4'd6); check("cont.c1exit.state", s0, 6'h0D);
    step(4'd7); check("cont.c1idle.state", s0, 6'h01); check("cont.c1idle.x", x0, 1);
    step(4'd1); check("cont.c0crit.fired", f0, 1); check("cont.c0crit.state", s0, 6'h02); check("cont.crit_count", cc0, 2);

    // Fairness: older client 2 must win over client 0
    do_reset;
    step(4'd8); step(4'd15); step(4'd15); step(4'd0);
    step(4'd1); check("fair.c0reject.fired", f1, 0); check("fair.c0reject.state", s1, 6'h11);
    step(4'd9); check("fair.c2crit.fired", f1, 1); check("fair.c2crit.state", s1, 6'h21);

    // Starvation timing and saturated-age tie broken by index
    do_reset;
    step(4'd0); step(4'd4);
    repeat (254) step(4'd15);
    check("starve.before", st0, 3'b001);
    step(4'd15);
    check("starve.rise0", st0, 3'b011); check("starve.rise1", st1, 3'b011);
    step(4'd5);
    check("tie.c1.nofair.fired", f0, 1); check("tie.c1.fair.fired", f1, 0);
    check("starve.clear", st0, 3'b001); check("starve.fair.hold", st1, 3'b011);
    step(4'd1);
    check("tie.c0.nofair.fired", f0, 0); check("tie.c0.fair.fired", f1, 1);
    check("tie.fair.starve", st1, 3'b010); check("tie.fair.state", s1, 6'h06);

    // Reset in the middle of operation
    do_reset;
    for (int k = 0; k < 4; k++) begin step(4'd0); step(4'd1); step(4'd2); step(4'd3); end
    step(4'd8); step(4'd0); step(4'd1);
    check("mid.crit_count", cc0, 5); check("mid.state", s0, 6'h12);
    #2 reset = 0;
    #1;
    check("arst.state", s0, 0); check("arst.x", x0, 1); check("arst.crit", cc0, 0);
    check("arst.fired", f0, 0); check("arst.starve", st0, 0); check("arst.err", e0, 0);
    @(negedge clock);
    reset = 1;

    // Forced safety violation: err is one cycle late and sticky
    step(4'd15);
    chk_en = 0;
    force dut0.state_q = 6'b001010;
    #1 check("err.before_edge", e0, 0);
    @(posedge clock); @(negedge clock);
    check("err.rise", e0, 1);
    release dut0.state_q;
    step(4'd15); check("err.sticky1", e0, 1);
    step(4'd2);  check("err.sticky2", e0, 1);
    step(4'd15); check("err.sticky3", e0, 1);
    do_reset;
    check("err.cleared", e0, 0);
    chk_en = 1;

    // Randomized rule stream, checked every cycle by the compare process
    do_reset;
    for (int i = 0; i < 3000; i++) step(4'($urandom_range(0, 15)));

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
